// File: rtl/mdu_seq_ctrl.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_DIV_EN to build the divider; without it, divide ops complete immediately with illegal=1.
module mdu_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]         op_q;
  logic               sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
  logic [CW-1:0]      cnt;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, mul_add;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   mul_word, fix_val;
  logic               early;

`ifdef MDU_DIV_EN
  logic               skip_q;
  logic               div_zero, div_ovf;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
`endif

  // Operand conditioning: signedness follows funct3, magnitudes feed the unsigned core.
  always_comb begin
    neg_a = op_a[WIDTH-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                             (funct3 == 3'b100) | (funct3 == 3'b110));
    neg_b = op_b[WIDTH-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110));
    mag_a = neg_a ? ('0 - op_a) : op_a;
    mag_b = neg_b ? ('0 - op_b) : op_b;
`ifdef MDU_DIV_EN
    div_zero = (op_b == '0);
    div_ovf  = ~funct3[0] & (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&op_b);
    early    = div_zero | div_ovf;
`else
    early    = 1'b0;
`endif
  end

  // Iteration datapath; acc_lo doubles as multiplier (mul) or quotient (div).
  always_comb begin
    mul_sum = {1'b0, acc_hi} + {1'b0, mcand};
    mul_add = acc_lo[0] ? mul_sum : {1'b0, acc_hi};
`ifdef MDU_DIV_EN
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand};
`endif
  end

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (sign_a_q ^ sign_b_q) ? ('0 - prod) : prod;
    mul_word = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    fix_val  = mul_word;
`ifdef MDU_DIV_EN
    quot_fix = (sign_a_q ^ sign_b_q) ? ('0 - acc_lo) : acc_lo;
    rem_fix  = sign_a_q ? ('0 - acc_hi) : acc_hi;
    if (op_q[2]) begin
      if (skip_q) begin
        fix_val = op_q[1] ? acc_hi : acc_lo;
      end else begin
        fix_val = op_q[1] ? rem_fix : quot_fix;
      end
    end
`else
    if (op_q[2]) begin
      fix_val = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef MDU_DIV_EN
          state_nxt = (funct3[2] && early) ? S_FIX : S_CALC;
`else
          state_nxt = funct3[2] ? S_DONE : S_CALC;
`endif
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    stall = (start & (state == S_IDLE)) | (busy & ~done);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      cnt      <= '0;
      result   <= '0;
      illegal  <= 1'b0;
`ifdef MDU_DIV_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= funct3;
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            cnt      <= CW'(WIDTH);
            illegal  <= 1'b0;
            acc_hi   <= '0;
            if (funct3[2]) begin
`ifdef MDU_DIV_EN
              mcand  <= mag_b;
              acc_lo <= mag_a;
              skip_q <= early;
              // Early results are preloaded as final {rem, quot} and bypass sign fix-up.
              if (div_zero) begin
                acc_hi <= op_a;
                acc_lo <= '1;
              end else if (div_ovf) begin
                acc_lo <= op_a;
              end
`else
              result  <= '0;
              illegal <= 1'b1;
`endif
            end else begin
              mcand  <= mag_a;
              acc_lo <= mag_b;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
`ifdef MDU_DIV_EN
          if (op_q[2]) begin
            if (!rem_diff[WIDTH]) begin
              acc_hi <= rem_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_add, acc_lo[WIDTH-1:1]};
          end
`else
          {acc_hi, acc_lo} <= {mul_add, acc_lo[WIDTH-1:1]};
`endif
        end
        S_FIX: begin
          result <= fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed testbench for mdu_seq_ctrl (WIDTH=32); divide expectations follow MDU_DIV_EN.
module tb_mdu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done, illegal;
  logic [31:0] result;

  int nvec = 0;
  int nerr = 0;

  mdu_seq_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Issues one op at the next negedge (cycle 0) and returns the cycle at which done is seen (-1 on timeout).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic ill);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    lat    = -1;
    res    = 'x;
    ill    = 1'bx;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
      end
      if (done) begin
        lat = c;
        res = result;
        ill = illegal;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    funct3 = '0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    nvec++; if (busy !== 1'b0)     begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
    nvec++; if (done !== 1'b0)     begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
    nvec++; if (stall !== 1'b0)    begin nerr++; $display("FAIL reset_stall got %b exp 0", stall); end
    nvec++; if (result !== 32'h0)  begin nerr++; $display("FAIL reset_result got %h exp 0", result); end
    nvec++; if (illegal !== 1'b0)  begin nerr++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0]  tf [9]  = '{3'b011, 3'b000, 3'b001, 3'b010, 3'b001, 3'b010, 3'b011, 3'b000, 3'b001};
    logic [31:0] ta [9]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                             32'h00000002, 32'h80000000, 32'h12345678, 32'hFFFFFFFD};
    logic [31:0] tb [9]  = '{32'hFFFFFFFF, 32'h00000007, 32'h00000007, 32'hFFFFFFFF, 32'h80000000,
                             32'h80000000, 32'h00000002, 32'h00000010, 32'hFFFFFFF9};
    logic [31:0] te [9]  = '{32'hFFFFFFFE, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000,
                             32'h00000001, 32'h00000001, 32'h23456780, 32'h00000000};
    int lat;
    logic [31:0] res;
    logic ill;
    for (int i = 0; i < 9; i++) begin
      run_op(tf[i], ta[i], tb[i], lat, res, ill);
      nvec++; if (res !== te[i]) begin nerr++; $display("FAIL mul_result[%0d] got %h exp %h", i, res, te[i]); end
      nvec++; if (lat !== 34)    begin nerr++; $display("FAIL mul_latency[%0d] got %0d exp 34", i, lat); end
      nvec++; if (ill !== 1'b0)  begin nerr++; $display("FAIL mul_illegal[%0d] got %b exp 0", i, ill); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  tf [12] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b100, 3'b110,
                             3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] ta [12] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000, 32'h80000000,
                             32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] tb [12] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0};
    logic [31:0] te [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'd0,
                             32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF9};
    int          tl [12] = '{34, 34, 2, 2, 2, 2, 34, 34, 34, 34, 2, 2};
    int lat, exp_lat;
    logic [31:0] res, exp_res;
    logic ill, exp_ill;
    for (int i = 0; i < 12; i++) begin
      run_op(tf[i], ta[i], tb[i], lat, res, ill);
`ifdef MDU_DIV_EN
      exp_res = te[i];
      exp_lat = tl[i];
      exp_ill = 1'b0;
`else
      exp_res = '0;
      exp_lat = 1;
      exp_ill = 1'b1;
`endif
      nvec++; if (res !== exp_res) begin nerr++; $display("FAIL div_result[%0d] got %h exp %h", i, res, exp_res); end
      nvec++; if (lat !== exp_lat) begin nerr++; $display("FAIL div_latency[%0d] got %0d exp %0d", i, lat, exp_lat); end
      nvec++; if (ill !== exp_ill) begin nerr++; $display("FAIL div_illegal[%0d] got %b exp %b", i, ill, exp_ill); end
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    int done_at = -1;
    logic [31:0] res = 'x;
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'h12345678;
    op_b   = 32'h00000010;
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL ign_stall[0] got %b exp 1", stall); end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 20);
      if (start) begin
        funct3 = 3'b011;
        op_a   = 32'hFFFFFFFF;
        op_b   = 32'hFFFFFFFF;
      end
      #1;
      if (done) begin
        ndone++;
        done_at = c;
        res = result;
      end
      if (c <= 34) begin
        nvec++;
        if (stall !== (c <= 33)) begin
          nerr++;
          $display("FAIL ign_stall[%0d] got %b exp %b", c, stall, (c <= 33));
        end
      end
    end
    nvec++; if (ndone !== 1)          begin nerr++; $display("FAIL ign_done_count got %0d exp 1", ndone); end
    nvec++; if (done_at !== 34)       begin nerr++; $display("FAIL ign_done_cycle got %0d exp 34", done_at); end
    nvec++; if (res !== 32'h23456780) begin nerr++; $display("FAIL ign_result got %h exp 23456780", res); end
  endtask

  task automatic test_back_to_back();
    int lat, nbad;
    logic [31:0] res;
    logic ill;
    run_op(3'b000, 32'd3, 32'd5, lat, res, ill);
    nvec++; if (res !== 32'd15) begin nerr++; $display("FAIL b2b_first got %h exp 0000000f", res); end
    // Start raised in the DONE cycle must be dropped.
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd2;
    op_b   = 32'd2;
    nbad   = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0) nbad++;
    end
    nvec++; if (nbad !== 0) begin nerr++; $display("FAIL done_start_ignored busy/done cycles got %0d exp 0", nbad); end
    run_op(3'b000, 32'd9, 32'd9, lat, res, ill);
    run_op(3'b000, 32'd11, 32'd12, lat, res, ill);
    nvec++; if (res !== 32'd132) begin nerr++; $display("FAIL b2b_second got %h exp 00000084", res); end
    nvec++; if (lat !== 34)      begin nerr++; $display("FAIL b2b_latency got %0d exp 34", lat); end
  endtask

  task automatic test_reset_abort();
    int lat, ndone;
    logic [31:0] res;
    logic ill;
    @(negedge clk);
    start = 1'b1;
`ifdef MDU_DIV_EN
    funct3 = 3'b101;
`else
    funct3 = 3'b011;
`endif
    op_a = 32'd100;
    op_b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b0)    begin nerr++; $display("FAIL abort_busy got %b exp 0", busy); end
    nvec++; if (done !== 1'b0)    begin nerr++; $display("FAIL abort_done got %b exp 0", done); end
    nvec++; if (result !== 32'h0) begin nerr++; $display("FAIL abort_result got %h exp 0", result); end
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    nvec++; if (ndone !== 0) begin nerr++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
    run_op(3'b000, 32'd6, 32'd7, lat, res, ill);
    nvec++; if (res !== 32'd42) begin nerr++; $display("FAIL abort_then_mul got %h exp 0000002a", res); end
    nvec++; if (lat !== 34)     begin nerr++; $display("FAIL abort_then_mul_latency got %0d exp 34", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
